// File: rtl/mock_channel.sv
`default_nettype none
// ============================================================================
// mock_channel : selector-channel sequencer driving a CU over tagged bus I/O
// Revision     : 1.0
// ============================================================================
module mock_channel #(
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  bus_out,
   output logic        bus_out_parity,
   input  logic [7:0]  bus_in,
   input  logic        bus_in_parity,
   output logic        operational_out,
   output logic        address_out,
   output logic        command_out,
   output logic        service_out,
   output logic        select_out,
   output logic        hold_out,
   output logic        suppress_out,
   input  logic        operational_in,
   input  logic        address_in,
   input  logic        status_in,
   input  logic        service_in,
   input  logic        select_in,
   input  logic        request_in,
   input  logic        start,
   input  logic [7:0]  dev_addr,
   input  logic [7:0]  cmd,
   input  logic [15:0] byte_count,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic [7:0]  status,
   output logic [15:0] residual,
   output logic        err_short_busy,
   output logic        err_no_device,
   output logic        err_addr_mismatch,
   output logic        err_timeout,
   output logic        err_parity
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_ADDR        = 4'd1,
      S_SEL_WAIT    = 4'd2,
      S_SHORT_BUSY  = 4'd3,
      S_ADDR_IN     = 4'd4,
      S_CMD         = 4'd5,
      S_INIT_STATUS = 4'd6,
      S_INIT_ACK    = 4'd7,
      S_DATA        = 4'd8,
      S_DATA_ACK    = 4'd9,
      S_STOP        = 4'd10,
      S_END_STATUS  = 4'd11,
      S_END_ACK     = 4'd12,
      S_END_DROP    = 4'd13,
      S_ABORT       = 4'd14,
      S_DONE        = 4'd15
   } state_t;

   localparam int c_E_SB  = 4;
   localparam int c_E_ND  = 3;
   localparam int c_E_AM  = 2;
   localparam int c_E_TO  = 1;
   localparam int c_E_PAR = 0;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_bus_out, w_bus_out_nxt;
   logic        r_addr_tag, w_addr_tag_nxt;
   logic        r_cmd_tag, w_cmd_tag_nxt;
   logic        r_svc_tag, w_svc_tag_nxt;
   logic        r_sel_tag, w_sel_tag_nxt;
   logic        r_hold_tag, w_hold_tag_nxt;
   logic [7:0]  r_dev_addr, w_dev_addr_nxt;
   logic [7:0]  r_cmd, w_cmd_nxt;
   logic [7:0]  r_status, w_status_nxt;
   logic [15:0] r_residual, w_residual_nxt;
   logic [7:0]  r_rd_data, w_rd_data_nxt;
   logic        r_rd_valid, w_rd_valid_nxt;
   logic [4:0]  r_err, w_err_nxt;
   logic [15:0] r_wdog, w_wdog_nxt;

   logic w_par_err, w_is_write, w_is_read, w_stop_status, w_wait_state, w_unused;

   // Odd parity: a correct byte+parity has an odd number of ones
   assign w_par_err     = ~(^{bus_in, bus_in_parity});
   assign w_is_write    = (r_cmd == 8'h01);
   assign w_is_read     = (r_cmd == 8'h02);
   assign w_stop_status = r_status[4] | (r_status[3] & r_status[2]) | r_status[1];
   assign w_unused      = request_in;

   always_comb begin
      w_wait_state = 1'b1;
      case (r_state)
         S_IDLE, S_ADDR, S_END_DROP, S_ABORT, S_DONE: w_wait_state = 1'b0;
         default:                                     w_wait_state = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bus_out_nxt  = r_bus_out;
      w_addr_tag_nxt = r_addr_tag;
      w_cmd_tag_nxt  = r_cmd_tag;
      w_svc_tag_nxt  = r_svc_tag;
      w_sel_tag_nxt  = r_sel_tag;
      w_hold_tag_nxt = r_hold_tag;
      w_dev_addr_nxt = r_dev_addr;
      w_cmd_nxt      = r_cmd;
      w_status_nxt   = r_status;
      w_residual_nxt = r_residual;
      w_rd_data_nxt  = r_rd_data;
      w_rd_valid_nxt = 1'b0;
      w_err_nxt      = r_err;
      w_wdog_nxt     = 16'd0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_dev_addr_nxt = dev_addr;
               w_cmd_nxt      = cmd;
               w_residual_nxt = byte_count;
               w_err_nxt      = 5'd0;
               w_bus_out_nxt  = dev_addr;
               w_addr_tag_nxt = 1'b1;
               w_state_nxt    = S_ADDR;
            end
         end
         S_ADDR: begin
            w_sel_tag_nxt  = 1'b1;
            w_hold_tag_nxt = 1'b1;
            w_state_nxt    = S_SEL_WAIT;
         end
         S_SEL_WAIT: begin
            if (operational_in) begin
               w_addr_tag_nxt = 1'b0;
               w_state_nxt    = S_ADDR_IN;
            end else if (status_in) begin
               w_status_nxt       = bus_in;
               w_err_nxt[c_E_SB]  = 1'b1;
               w_err_nxt[c_E_PAR] = r_err[c_E_PAR] | w_par_err;
               w_svc_tag_nxt      = 1'b1;
               w_sel_tag_nxt      = 1'b0;
               w_hold_tag_nxt     = 1'b0;
               w_addr_tag_nxt     = 1'b0;
               w_state_nxt        = S_SHORT_BUSY;
            end else if (select_in) begin
               w_err_nxt[c_E_ND] = 1'b1;
               w_addr_tag_nxt    = 1'b0;
               w_cmd_tag_nxt     = 1'b0;
               w_svc_tag_nxt     = 1'b0;
               w_sel_tag_nxt     = 1'b0;
               w_hold_tag_nxt    = 1'b0;
               w_state_nxt       = S_DONE;
            end
         end
         S_SHORT_BUSY: begin
            if (!status_in) begin
               w_svc_tag_nxt = 1'b0;
               w_state_nxt   = S_DONE;
            end
         end
         S_ADDR_IN: begin
            if (address_in) begin
               w_err_nxt[c_E_PAR] = r_err[c_E_PAR] | w_par_err;
               if (bus_in != r_dev_addr) begin
                  w_err_nxt[c_E_AM] = 1'b1;
                  w_state_nxt       = S_ABORT;
               end else begin
                  w_bus_out_nxt = r_cmd;
                  w_cmd_tag_nxt = 1'b1;
                  w_state_nxt   = S_CMD;
               end
            end
         end
         S_CMD: begin
            if (!address_in) begin
               w_cmd_tag_nxt = 1'b0;
               w_state_nxt   = S_INIT_STATUS;
            end
         end
         S_INIT_STATUS, S_END_STATUS: begin
            if (status_in) begin
               w_status_nxt       = bus_in;
               w_err_nxt[c_E_PAR] = r_err[c_E_PAR] | w_par_err;
               w_svc_tag_nxt      = 1'b1;
               w_state_nxt        = (r_state == S_INIT_STATUS) ? S_INIT_ACK : S_END_ACK;
            end
         end
         S_INIT_ACK: begin
            if (!status_in) begin
               w_svc_tag_nxt = 1'b0;
               if (w_stop_status)
                  w_state_nxt = S_END_DROP;
               else if (w_is_write || w_is_read)
                  w_state_nxt = S_DATA;
               else
                  w_state_nxt = S_END_STATUS;
            end
         end
         S_DATA: begin
            if (service_in) begin
               if (r_residual == 16'd0) begin
                  w_cmd_tag_nxt = 1'b1;
                  w_state_nxt   = S_STOP;
               end else if (w_is_write) begin
                  if (wr_valid) begin
                     w_bus_out_nxt  = wr_data;
                     w_svc_tag_nxt  = 1'b1;
                     w_residual_nxt = r_residual - 16'd1;
                     w_state_nxt    = S_DATA_ACK;
                  end
               end else begin
                  w_rd_data_nxt      = bus_in;
                  w_rd_valid_nxt     = 1'b1;
                  w_err_nxt[c_E_PAR] = r_err[c_E_PAR] | w_par_err;
                  w_svc_tag_nxt      = 1'b1;
                  w_residual_nxt     = r_residual - 16'd1;
                  w_state_nxt        = S_DATA_ACK;
               end
            end else if (status_in) begin
               // CU ended the transfer early; END_STATUS picks up this status
               w_state_nxt = S_END_STATUS;
            end
         end
         S_DATA_ACK: begin
            if (!service_in) begin
               w_svc_tag_nxt = 1'b0;
               w_state_nxt   = S_DATA;
            end
         end
         S_STOP: begin
            if (!service_in) begin
               w_cmd_tag_nxt = 1'b0;
               w_state_nxt   = S_END_STATUS;
            end
         end
         S_END_ACK: begin
            if (!status_in) begin
               w_svc_tag_nxt = 1'b0;
               w_state_nxt   = S_END_DROP;
            end
         end
         S_END_DROP: begin
            w_sel_tag_nxt  = 1'b0;
            w_hold_tag_nxt = 1'b0;
            w_state_nxt    = S_DONE;
         end
         S_ABORT: begin
            w_addr_tag_nxt = 1'b0;
            w_cmd_tag_nxt  = 1'b0;
            w_svc_tag_nxt  = 1'b0;
            w_sel_tag_nxt  = 1'b0;
            w_hold_tag_nxt = 1'b0;
            w_state_nxt    = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      // Watchdog only fires when the current wait state saw no progress
      if (w_wait_state && (w_state_nxt == r_state) && (r_wdog >= TIMEOUT - 16'd1)) begin
         w_err_nxt[c_E_TO] = 1'b1;
         w_state_nxt       = S_ABORT;
      end
      if (w_wait_state && (w_state_nxt == r_state))
         w_wdog_nxt = r_wdog + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_bus_out  <= 8'd0;
         r_addr_tag <= 1'b0;
         r_cmd_tag  <= 1'b0;
         r_svc_tag  <= 1'b0;
         r_sel_tag  <= 1'b0;
         r_hold_tag <= 1'b0;
         r_dev_addr <= 8'd0;
         r_cmd      <= 8'd0;
         r_status   <= 8'd0;
         r_residual <= 16'd0;
         r_rd_data  <= 8'd0;
         r_rd_valid <= 1'b0;
         r_err      <= 5'd0;
         r_wdog     <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_bus_out  <= w_bus_out_nxt;
         r_addr_tag <= w_addr_tag_nxt;
         r_cmd_tag  <= w_cmd_tag_nxt;
         r_svc_tag  <= w_svc_tag_nxt;
         r_sel_tag  <= w_sel_tag_nxt;
         r_hold_tag <= w_hold_tag_nxt;
         r_dev_addr <= w_dev_addr_nxt;
         r_cmd      <= w_cmd_nxt;
         r_status   <= w_status_nxt;
         r_residual <= w_residual_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_err      <= w_err_nxt;
         r_wdog     <= w_wdog_nxt;
      end
   end

   assign bus_out           = r_bus_out;
   assign bus_out_parity    = ~^r_bus_out;
   assign operational_out   = reset;
   assign suppress_out      = 1'b0;
   assign address_out       = r_addr_tag;
   assign command_out       = r_cmd_tag;
   assign service_out       = r_svc_tag;
   assign select_out        = r_sel_tag;
   assign hold_out          = r_hold_tag;
   assign wr_ready          = (r_state == S_DATA) && service_in && w_is_write && (r_residual != 16'd0);
   assign rd_data           = r_rd_data;
   assign rd_valid          = r_rd_valid;
   assign busy              = (r_state != S_IDLE);
   assign done              = (r_state == S_DONE);
   assign status            = r_status;
   assign residual          = r_residual;
   assign err_short_busy    = r_err[c_E_SB];
   assign err_no_device     = r_err[c_E_ND];
   assign err_addr_mismatch = r_err[c_E_AM];
   assign err_timeout       = r_err[c_E_TO];
   assign err_parity        = r_err[c_E_PAR];

endmodule
`default_nettype wire

// File: doc/mock_channel.md
MOCK_CHANNEL -- requirements
Module: mock_channel

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024: maximum number of clk cycles spent in any single wait state.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 bus_out / bus_out_parity  output  8 / 1  channel bus out, odd parity (parity bit = ~^bus_out).
REQ-005 bus_in / bus_in_parity  input  8 / 1  CU bus in, odd parity.
REQ-006 operational_out, address_out, command_out, service_out, select_out, hold_out, suppress_out  output  1 each  outbound tags.
REQ-007 operational_in, address_in, status_in, service_in, select_in, request_in  input  1 each  inbound tags; request_in is ignored.
REQ-008 start  input  1  one-cycle request; sampled only in IDLE.
REQ-009 dev_addr / cmd  input  8 / 8  device address and command byte, captured on start.
REQ-010 byte_count  input  16  data bytes to transfer, captured on start.
REQ-011 wr_data, wr_valid / wr_ready  input 8, input 1 / output 1  write data stream; a byte transfers when wr_valid and wr_ready are both high.
REQ-012 rd_data / rd_valid  output 8 / 1  read data; rd_valid is a one-cycle pulse per byte.
REQ-013 busy / done  output 1 / 1  busy is high outside IDLE; done is a one-cycle pulse on completion.
REQ-014 status, residual  output 8 / 16  last captured status byte; bytes not transferred.
REQ-015 err_short_busy, err_no_device, err_addr_mismatch, err_timeout, err_parity  output  1 each  result flags; cleared on start, valid with done.

Function
REQ-016 Outside reset, operational_out SHALL be 1.
REQ-017 suppress_out SHALL be 0 at all times.
REQ-018 bus_out_parity SHALL always be the odd parity of bus_out.
REQ-019 IDLE + start: latch inputs, drive bus_out=dev_addr and address_out=1, then go to ADDR.
REQ-020 ADDR (1 cycle, address settles): raise select_out and hold_out together, then go to SEL_WAIT.
REQ-021 SEL_WAIT, checked in priority order:
- operational_in -> drop address_out, go to ADDR_IN.
- status_in with operational_in low -> short busy: capture status, set err_short_busy, raise service_out, drop select_out/hold_out/address_out; hold service_out until status_in falls, then DONE.
- select_in -> set err_no_device, drop all outbound tags except operational_out, DONE.
REQ-022 ADDR_IN, on address_in:
- bus_in != dev_addr -> set err_addr_mismatch, go to ABORT.
- otherwise -> drive bus_out=cmd, raise command_out, go to CMD.
REQ-023 CMD: on address_in low, drop command_out and go to INIT_STATUS.
REQ-024 INIT_STATUS: on status_in, capture bus_in into status, raise service_out, go to INIT_ACK.
REQ-025 INIT_ACK: on status_in low, drop service_out. Exit:
- status[4] (busy) or status[3]&status[2] (CE+DE) or status[1] (UC) set -> go to END_DROP.
- cmd==8'h01 or 8'h02 -> go to DATA.
- otherwise -> go to END_STATUS.
REQ-026 DATA, on service_in:
- residual==0 -> raise command_out (stop), go to STOP.
- write -> present wr_data on bus_out with wr_ready=1; once the byte transfers (wait cycles allowed), raise service_out.
- read -> capture bus_in to rd_data, pulse rd_valid, raise service_out.
- either transfer decrements residual and goes to DATA_ACK.
REQ-027 DATA_ACK: on service_in low, drop service_out and return to DATA.
REQ-028 DATA: status_in instead of service_in -> CU ended early; go to END_STATUS with residual kept.
REQ-029 STOP: on service_in low, drop command_out and go to END_STATUS.
REQ-030 END_STATUS / END_ACK: same handshake as INIT_STATUS/INIT_ACK, then go to END_DROP.
REQ-031 END_DROP: drop select_out/hold_out, go to DONE.
REQ-032 ABORT: drop all outbound tags except operational_out, go to DONE.
REQ-033 DONE: pulse done for 1 cycle, return to IDLE.
REQ-034 Any parity error on bus_in while address_in, status_in, or a read service_in is sampled SHALL set err_parity (sticky); the sequence continues.
REQ-035 A 16-bit watchdog SHALL be cleared on every state change; reaching TIMEOUT sets err_timeout and goes to ABORT.
REQ-036 start received outside IDLE SHALL be ignored.

Reset
REQ-037 While reset is low, all outputs SHALL be 0: tags, wr_ready, rd_valid, done, busy, status, residual, and flags.
REQ-038 Reset SHALL force IDLE from any state, including mid-data, and drop all tags asynchronously.

Verification
REQ-039 NOP (cmd 03) to 0xFF against mock CU -> status 8'h0C, no data phase, done, all error flags 0.
REQ-040 READ, byte_count 4, CU limit 4 -> rd_data 01,02,03,04; status 8'h0C; residual 0.
REQ-041 WRITE, byte_count 2, CU limit 8 -> two bytes sent; stop via command_out on the third service_in; status 8'h0C; residual 0.
REQ-042 CU short busy -> operational_in never raised; status 8'h10; err_short_busy=1.
REQ-043 dev_addr 8'h10 with no device (select_in returns) -> err_no_device=1; done within 3 cycles.
REQ-044 reset asserted during the READ data phase -> all tags 0 in the same cycle; busy 0; next start runs normally.
